ifetch_controller: RTL and testbench
====================================

Name: ifetch_controller

Overview:
- Sequences instruction fetch from the 32-entry, 8-bit-wide IMEM.
- Owns the program counter and drives the IMEM read address. IMEM is combinational.
- Registers the returned instruction into an IR stage and hands it to decode with a valid/ready handshake.
- Handles branch redirects, halt detection and start/restart.

Parameters:
- MEM_DEPTH, 32, number of IMEM entries; must be a power of two and ≤ 256.
- RESET_PC, 8'h00, PC value after reset and on Start from IDLE/HALT.
- HALT_INSTR, 8'hFF, instruction encoding that halts fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  begin fetching (IDLE/HALT → FETCH).
- Read_Address  output  8  IMEM address; equals PC combinationally.
- Instruction_In  input  8  IMEM read data for Read_Address, same cycle.
- IR  output  8  registered instruction to decode.
- IR_PC  output  8  address IR was fetched from.
- IR_Valid  output  1  IR holds an unconsumed instruction.
- IR_Ready  input  1  decode accepts IR this cycle when IR_Valid=1.
- Branch_Taken  input  1  redirect request, single-cycle pulse.
- Branch_Target  input  8  redirect address.
- Halted  output  1  high while in HALT.
- Fetch_Count  output  16  perf counter; see Optional Feature.
- Stall_Count  output  16  perf counter; see Optional Feature.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, PC=RESET_PC, IR=0, IR_PC=0, IR_Valid=0, Halted=0, counters=0.
  - Reset mid-fetch discards IR immediately.
- Address generation:
  - Read_Address = PC, always, combinational.
  - PC arithmetic is modulo MEM_DEPTH: PC+1 wraps (MEM_DEPTH-1) → 0.
  - Branch_Target is masked to its low log2(MEM_DEPTH) bits, e.g. 8'h25 → 5 at depth 32.
- State IDLE:
  - IR_Valid=0.
  - Start=1 → PC=RESET_PC, go to FETCH.
  - Branch_Taken is ignored.
- State FETCH, priority order:
  1. Branch_Taken=1: PC ← target, IR_Valid ← 0 (flushes IR even if IR_Ready=1 the same cycle), stay in FETCH.
  2. Else, if the slot is free (IR_Valid=0 or IR_Ready=1):
     - IR ← Instruction_In, IR_PC ← PC, IR_Valid ← 1.
     - If Instruction_In == HALT_INSTR: PC unchanged, go to HALT.
     - Otherwise PC ← PC+1.
  3. Else (IR_Valid=1, IR_Ready=0): stall. Hold PC, IR and IR_PC.
- Timing:
  - One instruction per cycle at full throughput.
  - Latency Start → first IR_Valid is 2 cycles: Start is sampled at edge N, the PC=RESET_PC fetch loads IR at edge N+1, and IR_Valid is high after edge N+1.
- State HALT:
  - Halted=1.
  - The HALT instruction is still delivered to decode; IR_Valid clears when IR_Ready=1.
  - No further fetches.
  - Branch_Taken=1 → PC ← target, IR_Valid ← 0, go to FETCH.
  - Start=1, with no branch that cycle → PC ← RESET_PC, IR_Valid ← 0, go to FETCH.
- Simultaneous Start and Branch_Taken in HALT: branch wins.
- In FETCH, Start is ignored.
- IR, IR_PC and IR_Valid change only on clock edges (or reset); no combinational path from IR_Ready to IR outputs.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Fetch_Count increments on each IR load.
  - Stall_Count increments on each FETCH cycle with IR_Valid=1 and IR_Ready=0.
  - Both are 16-bit, saturate at 16'hFFFF and are cleared by reset only.
- Undefined: both outputs tied to 0; no counter flops synthesized.

Test Plan:
- Reset, Start pulse, IMEM[0..3]=8'h49,8'h12,8'h34,8'h56, IR_Ready=1 → IR sequence 49,12,34,56 on consecutive cycles, IR_PC 0,1,2,3; first IR_Valid exactly 2 cycles after Start.
- Hold IR_Ready=0 for 3 cycles with IR=8'h12 → IR, IR_PC=1 and Read_Address=2 stable; Stall_Count=3 with IFETCH_PERF_EN; on release, 8'h34 follows next cycle.
- Branch_Taken with Branch_Target=8'h25 while IR_Valid=1, IR_Ready=1 → next cycle IR_Valid=0, Read_Address=5; the following cycle IR=IMEM[5], IR_PC=5.
- Free-run from PC=30 (no halt) → Read_Address 30,31,0,1; IR_PC wraps likewise.
- IMEM[2]=8'hFF → IR=FF delivered with IR_PC=2, Halted=1, Read_Address frozen at 2; then Start → Halted=0, fetch resumes at RESET_PC.
- Assert rst_n=0 asynchronously mid-stall → IR_Valid=0, IR=0, state IDLE before the next clock edge; no fetch until Start.

Source files
------------

// File: rtl/ifetch_controller_if.sv
// ifetch_controller_if: IMEM bus, decode handshake, control and perf signals of the fetch stage
interface ifetch_controller_if;
  logic        Start;
  logic [7:0]  Read_Address;
  logic [7:0]  Instruction_In;
  logic [7:0]  IR;
  logic [7:0]  IR_PC;
  logic        IR_Valid;
  logic        IR_Ready;
  logic        Branch_Taken;
  logic [7:0]  Branch_Target;
  logic        Halted;
  logic [15:0] Fetch_Count;
  logic [15:0] Stall_Count;
  modport master (
    input  Start, Instruction_In, IR_Ready, Branch_Taken, Branch_Target,
    output Read_Address, IR, IR_PC, IR_Valid, Halted, Fetch_Count, Stall_Count
  );
  modport slave (
    output Start, Instruction_In, IR_Ready, Branch_Taken, Branch_Target,
    input  Read_Address, IR, IR_PC, IR_Valid, Halted, Fetch_Count, Stall_Count
  );
endinterface

// File: rtl/ifetch_controller.sv
// ifetch_controller: PC/IR fetch stage with branch redirect, halt and start; IFETCH_PERF_EN adds perf counters
module ifetch_controller #(
  parameter int          MEM_DEPTH  = 32,
  parameter logic [7:0]  RESET_PC   = 8'h00,
  parameter logic [7:0]  HALT_INSTR = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ifetch_controller_if.master   bus
);
  localparam logic [7:0] MASK = 8'(MEM_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d, ir_q, ir_d, ir_pc_q, ir_pc_d;
  logic       ir_v_q, ir_v_d;
  logic       free;
  assign free = !ir_v_q || bus.IR_Ready;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    ir_v_d  = ir_v_q;
    case (state_q)
      IDLE: if (bus.Start) begin
        pc_d    = RESET_PC & MASK;
        state_d = FETCH;
      end
      FETCH: if (bus.Branch_Taken) begin
        pc_d   = bus.Branch_Target & MASK;
        ir_v_d = 1'b0;
      end else if (free) begin
        ir_d    = bus.Instruction_In;
        ir_pc_d = pc_q;
        ir_v_d  = 1'b1;
        // the halt word is delivered but the PC stays on it
        state_d = bus.Instruction_In == HALT_INSTR ? HALT : FETCH;
        pc_d    = bus.Instruction_In == HALT_INSTR ? pc_q : (pc_q + 8'd1) & MASK;
      end
      HALT: if (bus.Branch_Taken || bus.Start) begin
        pc_d    = bus.Branch_Taken ? bus.Branch_Target & MASK : RESET_PC & MASK;
        ir_v_d  = 1'b0;
        state_d = FETCH;
      end else if (bus.IR_Ready) begin
        ir_v_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & MASK;
      ir_q    <= 8'h00;
      ir_pc_q <= 8'h00;
      ir_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      ir_v_q  <= ir_v_d;
    end
  end
  assign bus.Read_Address = pc_q;
  assign bus.IR           = ir_q;
  assign bus.IR_PC        = ir_pc_q;
  assign bus.IR_Valid     = ir_v_q;
  assign bus.Halted       = state_q == HALT;
`ifdef IFETCH_PERF_EN
  logic [15:0] fc_q, sc_q;
  logic        load, stall;
  assign load  = state_q == FETCH && !bus.Branch_Taken && free;
  assign stall = state_q == FETCH && ir_v_q && !bus.IR_Ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q <= 16'h0000;
      sc_q <= 16'h0000;
    end else begin
      if (load && !(&fc_q)) fc_q <= fc_q + 16'd1;
      if (stall && !(&sc_q)) sc_q <= sc_q + 16'd1;
    end
  end
  assign bus.Fetch_Count = fc_q;
  assign bus.Stall_Count = sc_q;
`else
  assign bus.Fetch_Count = 16'h0000;
  assign bus.Stall_Count = 16'h0000;
`endif
endmodule

// File: tb/tb_ifetch_controller.sv
// tb_ifetch_controller: vector table, directed halt/reset sequences and random run against a reference model
module tb_ifetch_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] mem [32];
  int total = 0, bad = 0;
  int m_mode, m_pc, m_ir, m_irpc, m_v, m_fc, m_sc;
  ifetch_controller_if bus();
  ifetch_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.Instruction_In = mem[bus.Read_Address[4:0]];
  typedef struct {
    logic s, r, b;
    logic [7:0] t;
    logic v;
    logic [7:0] ir, irpc, ra;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ir = 0; m_irpc = 0; m_v = 0; m_fc = 0; m_sc = 0;
  endtask
  task automatic model_step();
    if (m_mode == 0) begin
      if (bus.Start) begin m_pc = 0; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (m_v == 1 && !bus.IR_Ready && m_sc < 65535) m_sc++;
      if (bus.Branch_Taken) begin
        m_pc = int'(bus.Branch_Target) % 32; m_v = 0;
      end else if (m_v == 0 || bus.IR_Ready) begin
        m_ir = int'(mem[m_pc]); m_irpc = m_pc; m_v = 1;
        if (m_fc < 65535) m_fc++;
        if (m_ir == 255) m_mode = 2; else m_pc = (m_pc + 1) % 32;
      end
    end else begin
      if (bus.Branch_Taken) begin m_pc = int'(bus.Branch_Target) % 32; m_v = 0; m_mode = 1; end
      else if (bus.Start) begin m_pc = 0; m_v = 0; m_mode = 1; end
      else if (bus.IR_Ready) m_v = 0;
    end
  endtask
  task automatic model_chk();
    chk("read_address", 16'(bus.Read_Address), 16'(m_pc));
    chk("ir", 16'(bus.IR), 16'(m_ir));
    chk("ir_pc", 16'(bus.IR_PC), 16'(m_irpc));
    chk("ir_valid", 16'(bus.IR_Valid), 16'(m_v));
    chk("halted", 16'(bus.Halted), 16'(m_mode == 2));
`ifdef IFETCH_PERF_EN
    chk("fetch_count", bus.Fetch_Count, 16'(m_fc));
    chk("stall_count", bus.Stall_Count, 16'(m_sc));
`else
    chk("fetch_count", bus.Fetch_Count, 16'h0000);
    chk("stall_count", bus.Stall_Count, 16'h0000);
`endif
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    model_chk();
  endtask
  task automatic drive(logic s, logic r, logic b, logic [7:0] t);
    bus.Start = s; bus.IR_Ready = r; bus.Branch_Taken = b; bus.Branch_Target = t;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h60 + i);
    mem[0] = 8'h49; mem[1] = 8'h12; mem[2] = 8'h34; mem[3] = 8'h56;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h49, 8'h00, 8'h01};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 8'h01, 8'h02};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 8'h01, 8'h02};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 8'h01, 8'h02};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 8'h01, 8'h02};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h34, 8'h02, 8'h03};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h56, 8'h03, 8'h04};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h25, 1'b0, 8'h56, 8'h03, 8'h05};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h65, 8'h05, 8'h06};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h1E, 1'b0, 8'h65, 8'h05, 8'h1E};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h7E, 8'h1E, 8'h1F};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h7F, 8'h1F, 8'h00};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h49, 8'h00, 8'h01};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 8'h01, 8'h02};
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    model_reset();
    #2;
    model_chk();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].s, tbl[i].r, tbl[i].b, tbl[i].t);
      cyc();
      chk($sformatf("vec%0d_valid", i), 16'(bus.IR_Valid), 16'(tbl[i].v));
      chk($sformatf("vec%0d_ir", i), 16'(bus.IR), 16'(tbl[i].ir));
      chk($sformatf("vec%0d_irpc", i), 16'(bus.IR_PC), 16'(tbl[i].irpc));
      chk($sformatf("vec%0d_ra", i), 16'(bus.Read_Address), 16'(tbl[i].ra));
`ifdef IFETCH_PERF_EN
      if (i == 5) chk("stall3", bus.Stall_Count, 16'd3);
`endif
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    cyc();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", 16'(bus.IR_Valid), 16'h0);
    chk("async_rst_ir", 16'(bus.IR), 16'h0);
    chk("async_rst_ra", 16'(bus.Read_Address), 16'h0);
    model_chk();
    #1;
    rst_n = 1'b1;
    mem[2] = 8'hFF;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    cyc();
    cyc();
    chk("idle_no_fetch", 16'(bus.IR_Valid), 16'h0);
    drive(1'b0, 1'b1, 1'b1, 8'h09);
    cyc();
    chk("idle_ignores_branch", 16'(bus.Read_Address), 16'h0);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    cyc();
    cyc();
    cyc();
    chk("halt_ir", 16'(bus.IR), 16'h00FF);
    chk("halt_irpc", 16'(bus.IR_PC), 16'h0002);
    chk("halt_flag", 16'(bus.Halted), 16'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    cyc();
    cyc();
    chk("halt_ra_frozen", 16'(bus.Read_Address), 16'h0002);
    chk("halt_held_valid", 16'(bus.IR_Valid), 16'h1);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    cyc();
    chk("halt_consumed", 16'(bus.IR_Valid), 16'h0);
    cyc();
    chk("halt_no_fetch", 16'(bus.IR_Valid), 16'h0);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    cyc();
    chk("restart_halted", 16'(bus.Halted), 16'h0);
    chk("restart_ra", 16'(bus.Read_Address), 16'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    cyc();
    chk("restart_ir", 16'(bus.IR), 16'h0049);
    cyc();
    cyc();
    chk("rehalt", 16'(bus.Halted), 16'h1);
    drive(1'b1, 1'b1, 1'b1, 8'h29);
    cyc();
    chk("branch_beats_start", 16'(bus.Read_Address), 16'h0009);
    chk("branch_unhalt", 16'(bus.Halted), 16'h0);
    for (int i = 0; i < 32; i++) mem[i] = ($urandom % 8 == 0) ? 8'hFF : 8'($urandom % 255);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom % 8 == 0, $urandom % 4 != 0, $urandom % 8 == 0, 8'($urandom));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
